// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seg7_scan 4-digit hex display driver.
package seg7_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam logic [3:0] AN_OFF     = 4'hF;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int calc_div(input int clk_freq, input int scan_freq);
        return clk_freq / scan_freq;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low 7-segment decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 4-digit hex display driver with per-frame snapshot and anti-ghost guard.
// Optional leading-zero blanking when SEG7_LZ_BLANK_EN is defined.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int SCAN_FREQ    = 1000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [15:0] value_i,
    input  logic        enable_i,
    output logic [3:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        dp_o
);

    localparam int DIV = calc_div(CLK_FREQ, SCAN_FREQ);
    localparam int PW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int GW  = (GUARD_CYCLES < 1) ? 1 : $clog2(GUARD_CYCLES + 1);

    if (DIV < 2 || GUARD_CYCLES >= DIV) begin : g_bad_params
        $error("seg7_scan: need CLK_FREQ/SCAN_FREQ >= 2 and GUARD_CYCLES < CLK_FREQ/SCAN_FREQ");
    end

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [GW-1:0] guard;
    logic [15:0]   snap;
    logic          first;

    logic          tick;
    logic [3:0]    nibble;
    logic [6:0]    seg_dec;
    logic          lit;
    logic          blank;
    logic [15:0]   upper;

    assign tick = (presc == PW'(DIV - 1));

    // NOTE: always_comb outputs get a default first so no path leaves them unassigned (no latch).
    always_comb begin
        nibble = snap[3:0];
        case (idx)
            2'd1:    nibble = snap[7:4];
            2'd2:    nibble = snap[11:8];
            2'd3:    nibble = snap[15:12];
            default: nibble = snap[3:0];
        endcase
    end

    hex_to_seg7 u_dec (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    always_comb begin
        upper = snap >> {idx, 2'b00};
`ifdef SEG7_LZ_BLANK_EN
        lit = (idx == 2'd0) || (upper != 16'h0000);
`else
        lit = 1'b1;
`endif
        blank = !enable_i || (guard != '0) || !lit;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            presc <= '0;
            idx   <= 2'd0;
            guard <= GW'(GUARD_CYCLES);
            snap  <= 16'h0000;
            first <= 1'b1;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            first <= 1'b0;
            if (tick) begin
                idx   <= idx + 2'd1;
                guard <= GW'(GUARD_CYCLES);
            end else if (guard != '0) begin
                guard <= guard - 1'b1;
            end
            // Frame boundary: the new value is shown from digit 0 of the next frame.
            if (first || (tick && idx == 2'd3)) begin
                snap <= value_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            an_o  <= AN_OFF;
            seg_o <= SEG_OFF;
            dp_o  <= 1'b1;
        end else begin
            an_o  <= blank ? AN_OFF : ~(4'b0001 << idx);
            seg_o <= blank ? SEG_OFF : seg_dec;
            dp_o  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan (DIV=4, GUARD_CYCLES=1) against a cycle-count reference model.
module tb_seg7_scan;

    localparam int DIV   = 4;
    localparam int G     = 1;
    localparam int FRAME = 4 * DIV;
    localparam int HMAX  = 4096;

    logic        clk_i    = 1'b0;
    logic        reset_i  = 1'b1;
    logic        enable_i = 1'b1;
    logic [15:0] value_i  = 16'h0000;
    logic [3:0]  an_o;
    logic [6:0]  seg_o;
    logic        dp_o;

    int passed = 0;
    int total  = 0;

    seg7_scan #(.CLK_FREQ(8), .SCAN_FREQ(2), .GUARD_CYCLES(G)) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .value_i  (value_i),
        .enable_i (enable_i),
        .an_o     (an_o),
        .seg_o    (seg_o),
        .dp_o     (dp_o)
    );

    always #5 clk_i = ~clk_i;

    logic [6:0] seg_ref [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Input history per clock edge since reset release; edge k sees val_hist[k], en_hist[k].
    int          cyc = 0;
    logic [15:0] val_hist [HMAX];
    logic        en_hist  [HMAX];

    always @(posedge clk_i or posedge reset_i) begin
        if (reset_i) cyc = 0;
        else if (cyc < HMAX - 1) begin
            cyc = cyc + 1;
            val_hist[cyc] = value_i;
            en_hist[cyc]  = enable_i;
        end
    end

    // Expected {an,seg} after edge k: state seen is that after k-1 edges.
    function automatic logic [10:0] model(input int k);
        int          j;
        int          idx;
        logic [15:0] s;
        logic [3:0]  nib;
        logic [3:0]  an;
        if (k == 0) return {4'hF, 7'h7F};
        j = k - 1;
        if (!en_hist[k] || (j % DIV) < G) return {4'hF, 7'h7F};
        idx = (j / DIV) % 4;
        s   = val_hist[(j < FRAME) ? 1 : FRAME * (j / FRAME)];
`ifdef SEG7_LZ_BLANK_EN
        if (idx != 0 && (s >> (4 * idx)) == 16'h0000) return {4'hF, 7'h7F};
`endif
        nib = 4'((s >> (4 * idx)) & 16'h000F);
        an  = 4'hF;
        an[idx] = 1'b0;
        return {an, seg_ref[nib]};
    endfunction

    task automatic start(input logic [15:0] v);
        @(negedge clk_i);
        reset_i  = 1'b1;
        value_i  = v;
        enable_i = 1'b1;
        @(negedge clk_i);
        reset_i  = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        value_i = 16'hFFFF;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk_i);
            total++;
            if ({an_o, seg_o, dp_o} !== {4'hF, 7'h7F, 1'b1})
                $display("FAIL reset_hold an=%b seg=%h dp=%b expected an=1111 seg=7f dp=1", an_o, seg_o, dp_o);
            else passed++;
        end
    endtask

    task automatic test_full_frame();
        logic [10:0] exp;
        logic [10:0] seen [$];
        logic [10:0] want [4];
        int          blanks;
        want = '{{4'b1110, 7'h0E}, {4'b1101, 7'h30}, {4'b1011, 7'h08}, {4'b0111, 7'h79}};
        blanks = 0;
        start(16'h1A3F);
        for (int n = 0; n < 17; n++) begin
            @(negedge clk_i);
            exp = model(cyc);
            total++;
            if ({an_o, seg_o, dp_o} !== {exp, 1'b1})
                $display("FAIL full_frame k=%0d an=%b seg=%h dp=%b expected an=%b seg=%h dp=1", cyc, an_o, seg_o, dp_o, exp[10:7], exp[6:0]);
            else passed++;
            if (an_o == 4'hF && cyc >= 2) blanks++;
            if (an_o != 4'hF && (seen.size() == 0 || seen[$] !== {an_o, seg_o})) seen.push_back({an_o, seg_o});
        end
        total++;
        if (blanks !== 4) $display("FAIL guard_count blanks=%0d expected 4", blanks);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= seen.size() || seen[i] !== want[i])
                $display("FAIL digit_order idx=%0d got=%h expected=%h", i, (i < seen.size()) ? seen[i] : 11'h7FF, want[i]);
            else passed++;
        end
    endtask

    task automatic test_tear_free();
        logic [10:0] exp;
        start(16'h0003);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk_i);
            exp = model(cyc);
            total++;
            if ({an_o, seg_o, dp_o} !== {exp, 1'b1})
                $display("FAIL tear_free k=%0d an=%b seg=%h expected an=%b seg=%h", cyc, an_o, seg_o, exp[10:7], exp[6:0]);
            else passed++;
            if (cyc == 18) begin
                total++;
                if ({an_o, seg_o} !== {4'b1110, 7'h19})
                    $display("FAIL next_frame_digit0 an=%b seg=%h expected an=1110 seg=19", an_o, seg_o);
                else passed++;
            end
            if (cyc == 10) value_i = 16'h0004;
        end
    endtask

    task automatic test_enable();
        logic [10:0] exp;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk_i);
            exp = model(cyc);
            total++;
            if ({an_o, seg_o, dp_o} !== {exp, 1'b1})
                $display("FAIL enable k=%0d an=%b seg=%h expected an=%b seg=%h", cyc, an_o, seg_o, exp[10:7], exp[6:0]);
            else passed++;
            if (n == 6) begin
                total++;
                if ({an_o, seg_o} !== {4'hF, 7'h7F})
                    $display("FAIL enable_blank an=%b seg=%h expected an=1111 seg=7f", an_o, seg_o);
                else passed++;
            end
            if (n == 5)  enable_i = 1'b0;
            if (n == 11) enable_i = 1'b1;
        end
    endtask

    task automatic test_async_reset();
        logic [10:0] exp;
        value_i = 16'hBEEF;
        @(negedge clk_i);
        #2 reset_i = 1'b1;
        #1;
        total++;
        if ({an_o, seg_o, dp_o} !== {4'hF, 7'h7F, 1'b1})
            $display("FAIL async_reset an=%b seg=%h dp=%b expected an=1111 seg=7f dp=1", an_o, seg_o, dp_o);
        else passed++;
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk_i);
            exp = model(cyc);
            total++;
            if ({an_o, seg_o, dp_o} !== {exp, 1'b1})
                $display("FAIL post_reset k=%0d an=%b seg=%h expected an=%b seg=%h", cyc, an_o, seg_o, exp[10:7], exp[6:0]);
            else passed++;
            if (cyc == 2) begin
                total++;
                if (an_o !== 4'b1110) $display("FAIL restart_digit0 an=%b expected 1110", an_o);
                else passed++;
            end
        end
    endtask

    task automatic test_random();
        logic [10:0] exp;
        start(16'($urandom));
        for (int n = 0; n < 400; n++) begin
            @(negedge clk_i);
            exp = model(cyc);
            total++;
            if ({an_o, seg_o, dp_o} !== {exp, 1'b1})
                $display("FAIL random k=%0d an=%b seg=%h dp=%b expected an=%b seg=%h", cyc, an_o, seg_o, dp_o, exp[10:7], exp[6:0]);
            else passed++;
            if ($urandom_range(7, 0) == 0) value_i = 16'($urandom);
            if ($urandom_range(9, 0) == 0) enable_i = ~enable_i;
        end
        enable_i = 1'b1;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_tear_free();
        test_enable();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Downstream consumer of the core's 16-bit debug register output (r1_o from top). Shows the value as four hex digits on a common-anode, time-multiplexed 7-segment display.
- Runs on the 100 MHz board clock, not the divided core clock.
- Latches the input once per full scan frame so the displayed digits never tear while the core updates the register mid-frame.

Parameters:
- CLK_FREQ, 100_000_000: input clock frequency in Hz.
- SCAN_FREQ, 1000: per-digit refresh rate in Hz. One digit advance every CLK_FREQ/SCAN_FREQ cycles.
- GUARD_CYCLES, 2: cycles that all anodes stay off after each digit change (anti-ghosting). Must be less than CLK_FREQ/SCAN_FREQ.

Ports:
- clk_i, input, 1: board clock.
- reset_i, input, 1: asynchronous, active-high reset.
- value_i, input, 16: value to display (core r1_o).
- enable_i, input, 1: display enable. Low blanks the display.
- an_o, output, 4: digit anodes, active low. an_o[0] is the rightmost digit.
- seg_o, output, 7: segments {g,f,e,d,c,b,a}, active low.
- dp_o, output, 1: decimal point, active low. Held at 1 (off).

Behaviour:
- Reset (async, active-high):
  - prescaler=0, digit index=0, guard counter=GUARD_CYCLES, snapshot=16'h0000.
  - an_o=4'b1111, seg_o=7'b1111111, dp_o=1.
- Prescaler:
  - Counts 0..DIV-1 with DIV=CLK_FREQ/SCAN_FREQ.
  - When the count equals DIV-1, it wraps and asserts a one-cycle tick.
  - Elaboration error if DIV<2 or GUARD_CYCLES>=DIV.
- Digit index:
  - 2-bit counter, increments on tick, wraps 3->0.
  - Digit n displays snapshot[4n+3:4n].
- Snapshot:
  - Loads value_i on the tick where the digit index wraps 3->0 (frame boundary).
  - Also loads value_i on the first cycle after reset deassertion.
  - Changes to value_i at any other time have no visible effect until the next frame boundary.
- Guard:
  - On each tick, the guard counter reloads to GUARD_CYCLES. It decrements to 0 on each subsequent cycle.
  - While the guard counter is nonzero, an_o=4'b1111 and seg_o=7'b1111111.
- Outputs:
  - All outputs are registered: one cycle of latency from the internal state.
  - When not in guard, an_o has exactly one bit low (bit = digit index) and seg_o = decode(nibble).
- Decode table (active low), listed as nibble:seg_o:
  - 0:40, 1:79, 2:24, 3:30
  - 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03
  - C:46, d:21, E:06, F:0E
- enable_i low:
  - Next cycle: an_o=4'b1111 and seg_o=7'h7F.
  - Prescaler, digit index and snapshot keep running, so re-enable resumes mid-scan with no restart.
- Simultaneous events:
  - tick plus frame wrap in the same cycle: the new snapshot is used by digit 0 of the new frame.
  - reset asserted mid-frame: outputs are forced to their reset values immediately (asynchronous).

Optional Feature:
- Macro SEG7_LZ_BLANK_EN.
- Defined: leading-zero blanking, evaluated on the snapshot.
  - Any digit above the most significant nonzero nibble keeps its anode off (an_o bit stays 1) during its slot.
  - Digit 0 is always shown, so 16'h0000 displays a single "0".
  - Example: 16'h0003 lights only an_o[0].
- Undefined: all four digits are always shown, including leading zeros.

Decomposition:
- Package seg7_pkg:
  - NUM_DIGITS=4.
  - SEG_OFF=7'h7F, AN_OFF=4'hF.
  - 16-entry hex-to-segment constant table.
  - Function for the DIV computation.
- Sub-module hex_to_seg7: combinational 4-bit nibble to 7-bit active-low segment decoder, using the package table. Instantiated once, fed by a mux on the digit index.

Test Plan (CLK_FREQ=8, SCAN_FREQ=2, so DIV=4; GUARD_CYCLES=1):
- Reset hold: reset_i=1 with value_i=16'hFFFF -> an_o=4'hF, seg_o=7'h7F, dp_o=1 throughout.
- Full frame: value_i=16'h1A3F, release reset -> over 4 ticks, after each guard cycle, observe in order:
  - an_o=4'b1110, seg_o=0E
  - an_o=4'b1101, seg_o=30
  - an_o=4'b1011, seg_o=08
  - an_o=4'b0111, seg_o=79
  - Every digit change has exactly one cycle of an_o=4'hF.
- Tear-free: switch value_i from 16'h0003 to 16'h0004 while digit 2 is displayed -> digit 3 still shows 0 (seg_o=40) and digit 0 of the current frame is unaffected; the next frame's digit 0 shows seg_o=19.
- Enable: drop enable_i for 6 cycles -> an_o=4'hF and seg_o=7'h7F from the next cycle. Raise it again -> display resumes at the digit index advanced by the elapsed ticks.
- Async reset mid-scan: assert reset_i between clock edges -> an_o=4'hF before the next edge. After release, the scan restarts at digit 0.
- SEG7_LZ_BLANK_EN defined, value_i=16'h0003 -> across a full frame only an_o[0] ever goes low (seg_o=30). With 16'h0000 -> only digit 0 is lit (seg_o=40).
